encrypter_lane: RTL and testbench

One encryption lane, instantiated `NUM_ENCRYPTERS` times directly downstream of the QSPI parallelizer. It does three things:
- Latches the shared key while its program line is high.
- Accepts one data packet and key-rotation value per data-ready pulse.
- Runs a fixed multi-round XOR/rotate cipher, then presents the result until it is acknowledged.

Its `ready` output feeds the parallelizer's per-lane ready vector, which the parallelizer uses for round-robin dispatch and flow control.

---
 rtl/encrypter_pkg.sv | 32 +++
 rtl/encrypter_lane_if.sv | 44 ++++
 rtl/encrypter_round.sv | 16 +
 rtl/encrypter_lane.sv | 101 ++++++++++
 tb/tb_encrypter_lane.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encrypter_pkg.sv
// Shared constants, lane state encoding and the rotate helper for the encryption lanes.
package encrypter_pkg;

    localparam int ENCRYPTER_WIDTH    = 32;
    localparam int KEY_ROTATION_WIDTH = 5;
    localparam int ENCRYPTER_ROUNDS   = 4;

    // Widest value rotl can handle; callers zero-extend into it and cast back down.
    localparam int ROTL_MAX_W = 64;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_BUSY = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_t;

    // Rotate the low `width` bits of value left by amount (mod width).
    function automatic logic [ROTL_MAX_W-1:0] rotl(
        input logic [ROTL_MAX_W-1:0] value,
        input int unsigned           amount,
        input int unsigned           width
    );
        logic [ROTL_MAX_W-1:0] mask;
        logic [ROTL_MAX_W-1:0] v;
        int unsigned           a;
        a    = amount % width;
        mask = (ROTL_MAX_W'(1) << width) - ROTL_MAX_W'(1);
        v    = value & mask;
        rotl = ((v << a) | (v >> (width - a))) & mask;
    endfunction

endpackage

// File: rtl/encrypter_lane_if.sv
// Lane-side bus: shared data/key input, per-lane strobes, and the result handshake.
interface encrypter_lane_if
    import encrypter_pkg::*;
#(
    parameter int WIDTH = ENCRYPTER_WIDTH,
    parameter int ROT_W = KEY_ROTATION_WIDTH
) ();

    logic [WIDTH-1:0] data;
    logic [ROT_W-1:0] key_rotation;
    // Program line; `program` itself is a reserved word.
    logic             prog;
    logic             data_ready;
    logic             ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;
    logic             overrun;

    modport master (
        output data,
        output key_rotation,
        output prog,
        output data_ready,
        output out_ack,
        input  ready,
        input  out_valid,
        input  out_data,
        input  overrun
    );

    modport slave (
        input  data,
        input  key_rotation,
        input  prog,
        input  data_ready,
        input  out_ack,
        output ready,
        output out_valid,
        output out_data,
        output overrun
    );

endinterface

// File: rtl/encrypter_round.sv
// One cipher round: fold the round key into the data, then advance the round key.
module encrypter_round
    import encrypter_pkg::*;
#(
    parameter int WIDTH = ENCRYPTER_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] rk,
    output logic [WIDTH-1:0] d_next,
    output logic [WIDTH-1:0] rk_next
);

    assign d_next  = WIDTH'(rotl(ROTL_MAX_W'(d ^ rk), 3, WIDTH));
    assign rk_next = WIDTH'(rotl(ROTL_MAX_W'(rk), 1, WIDTH));

endmodule

// File: rtl/encrypter_lane.sv
// One encryption lane: key latch, single-packet accept, multi-round cipher, held result.
module encrypter_lane
    import encrypter_pkg::*;
#(
    parameter int WIDTH  = ENCRYPTER_WIDTH,
    parameter int ROT_W  = KEY_ROTATION_WIDTH,
    parameter int ROUNDS = ENCRYPTER_ROUNDS
) (
    input logic             clk,
    input logic             reset,
    encrypter_lane_if.slave lane
);

    localparam int              RND_W      = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS - 1);

    lane_state_t      state;
    lane_state_t      state_next;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] rk;
    logic [WIDTH-1:0] d_round;
    logic [WIDTH-1:0] rk_round;
    logic [WIDTH-1:0] out_data_q;
    logic [RND_W-1:0] round;
    logic [ROT_W-1:0] kr;
    logic             overrun_q;
    logic             accept;
    logic             last_round;

    assign kr = lane.key_rotation;

    // Programming takes priority over a packet strobe while idle.
    assign accept     = (state == LANE_IDLE) && !lane.prog && lane.data_ready;
    assign last_round = (state == LANE_BUSY) && (round == LAST_ROUND);

    encrypter_round #(
        .WIDTH (WIDTH)
    ) u_round (
        .d       (d),
        .rk      (rk),
        .d_next  (d_round),
        .rk_next (rk_round)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LANE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LANE_IDLE: if (accept)         state_next = LANE_BUSY;
            LANE_BUSY: if (last_round)     state_next = LANE_DONE;
            LANE_DONE: if (lane.out_ack)   state_next = LANE_IDLE;
            default:                       state_next = LANE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key        <= '0;
            d          <= '0;
            rk         <= '0;
            round      <= '0;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if ((state == LANE_IDLE) && lane.prog) begin
                key <= lane.data;
            end

            if (accept) begin
                d     <= lane.data;
                rk    <= WIDTH'(rotl(ROTL_MAX_W'(key), 32'(kr), WIDTH));
                round <= '0;
            end else if (state == LANE_BUSY) begin
                d     <= d_round;
                rk    <= rk_round;
                round <= round + RND_W'(1);
            end

            if (last_round) begin
                out_data_q <= d_round;
            end

            // A strobe outside IDLE drops the packet and flags it for one cycle.
            overrun_q <= lane.data_ready && (state != LANE_IDLE);
        end
    end

    assign lane.ready     = (state == LANE_IDLE);
    assign lane.out_valid = (state == LANE_DONE);
    assign lane.out_data  = out_data_q;
    assign lane.overrun   = overrun_q;

endmodule

// File: tb/tb_encrypter_lane.sv
// Self-checking bench for encrypter_lane: directed scenarios plus randomized packets vs a cipher model.
module tb_encrypter_lane;

    localparam int W      = 32;
    localparam int ROUNDS = 4;
    localparam int LAT    = ROUNDS;
    localparam int PERIOD = ROUNDS + 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    encrypter_lane_if #(.WIDTH(W), .ROT_W(5)) bus  ();
    encrypter_lane_if #(.WIDTH(W), .ROT_W(6)) bus6 ();

    encrypter_lane #(.WIDTH(W), .ROT_W(5), .ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .reset (reset),
        .lane  (bus.slave)
    );

    encrypter_lane #(.WIDTH(W), .ROT_W(6), .ROUNDS(ROUNDS)) dut6 (
        .clk   (clk),
        .reset (reset),
        .lane  (bus6.slave)
    );

    int checks   = 0;
    int failures = 0;
    int ovr_cnt0 = 0;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} << (n % 32);
        return t[63:32];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] key, input logic [31:0] data, input int rot);
        logic [31:0] dd;
        logic [31:0] kk;
        dd = data;
        kk = rol(key, rot);
        for (int r = 0; r < ROUNDS; r++) begin
            dd = rol(dd ^ kk, 3);
            kk = rol(kk, 1);
        end
        return dd;
    endfunction

    function automatic logic o_ready(input int sel);
        return (sel == 0) ? bus.ready : bus6.ready;
    endfunction
    function automatic logic o_valid(input int sel);
        return (sel == 0) ? bus.out_valid : bus6.out_valid;
    endfunction
    function automatic logic o_ovr(input int sel);
        return (sel == 0) ? bus.overrun : bus6.overrun;
    endfunction
    function automatic logic [31:0] o_data(input int sel);
        return (sel == 0) ? bus.out_data : bus6.out_data;
    endfunction

    task automatic drive(input int sel, input logic [31:0] d, input logic [5:0] kr,
                         input logic prog, input logic dr, input logic ack);
        if (sel == 0) begin
            bus.data = d; bus.key_rotation = kr[4:0]; bus.prog = prog;
            bus.data_ready = dr; bus.out_ack = ack;
        end else begin
            bus6.data = d; bus6.key_rotation = kr; bus6.prog = prog;
            bus6.data_ready = dr; bus6.out_ack = ack;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ovr_cnt0 += int'(bus.overrun);
    endtask

    task automatic idle_all();
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic program_key(input int sel, input logic [31:0] key, input int ncyc);
        drive(sel, key, '0, 1'b1, 1'b0, 1'b0);
        repeat (ncyc) step();
        drive(sel, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic accept(input int sel, input logic [31:0] data, input logic [5:0] kr);
        drive(sel, data, kr, 1'b0, 1'b1, 1'b0);
        step();
        drive(sel, data, kr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_valid(input int sel, output int n);
        n = 0;
        while (!o_valid(sel) && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic ack(input int sel);
        drive(sel, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        drive(sel, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        checks++; if (bus6.ready !== 1'b1) begin failures++; $display("FAIL reset_ready6 got=%b exp=1", bus6.ready); end
    endtask

    task automatic test_program_encrypt();
        int n;
        do_reset();
        drive(0, 32'h1, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL prog_ready cyc=%0d got=%b exp=1", i, bus.ready); end
        end
        drive(0, 32'h1, '0, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL prog_wins_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL prog_wins_overrun got=%b exp=0", bus.overrun); end
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        accept(0, 32'h0, 6'd0);
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL accept_ready got=%b exp=0", bus.ready); end
        wait_valid(0, n);
        checks++; if (n != LAT) begin failures++; $display("FAIL latency got=%0d exp=%0d", n, LAT); end
        checks++; if (bus.out_data !== 32'h00001540) begin failures++; $display("FAIL prog_encrypt got=%h exp=00001540", bus.out_data); end
        ack(0);
        checks++; if (bus.out_valid !== 1'b0 || bus.ready !== 1'b1) begin
            failures++; $display("FAIL ack valid=%b ready=%b exp 0/1", bus.out_valid, bus.ready);
        end
    endtask

    task automatic test_zero_key();
        int n;
        do_reset();
        accept(0, 32'h1, 6'd7);
        wait_valid(0, n);
        checks++; if (n != LAT) begin failures++; $display("FAIL zero_key_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (bus.out_data !== 32'h00001000) begin failures++; $display("FAIL zero_key got=%h exp=00001000", bus.out_data); end
        ack(0);
    endtask

    task automatic test_rotation_wrap();
        int n;
        do_reset();
        program_key(1, 32'h1, 1);
        accept(1, 32'h0, 6'd0);
        wait_valid(1, n);
        checks++; if (bus6.out_data !== 32'h00001540) begin failures++; $display("FAIL rot0 got=%h exp=00001540", bus6.out_data); end
        ack(1);
        accept(1, 32'h0, 6'd32);
        wait_valid(1, n);
        checks++; if (bus6.out_data !== 32'h00001540) begin failures++; $display("FAIL rot32 got=%h exp=00001540", bus6.out_data); end
        ack(1);
    endtask

    task automatic test_overrun_hold();
        logic [31:0] k, p, e;
        int r, n, base;
        do_reset();
        k = $urandom; p = $urandom; r = $urandom_range(0, 31);
        e = model(k, p, r);
        program_key(0, k, 1);
        base = ovr_cnt0;
        accept(0, p, 6'(r));
        drive(0, $urandom, 6'(r), 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL busy_overrun got=%b exp=1", bus.overrun); end
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL busy_overrun_pulse got=%b exp=0", bus.overrun); end
        wait_valid(0, n);
        for (int i = 0; i < 5; i++) begin
            if (i == 1)      drive(0, $urandom, '0, 1'b0, 1'b1, 1'b0);
            else if (i == 3) drive(0, ~k, '0, 1'b1, 1'b0, 1'b0);
            else             drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                failures++; $display("FAIL hold cyc=%0d valid=%b data=%h exp 1/%h", i, bus.out_valid, bus.out_data, e);
            end
        end
        checks++; if (ovr_cnt0 - base != 2) begin failures++; $display("FAIL overrun_count got=%0d exp=2", ovr_cnt0 - base); end
        ack(0);
        p = $urandom; r = $urandom_range(0, 31);
        accept(0, p, 6'(r));
        wait_valid(0, n);
        checks++; if (bus.out_data !== model(k, p, r)) begin
            failures++; $display("FAIL key_kept got=%h exp=%h", bus.out_data, model(k, p, r));
        end
        ack(0);
    endtask

    task automatic test_reset_mid();
        int n;
        program_key(0, $urandom, 1);
        accept(0, $urandom, 6'($urandom_range(0, 31)));
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_state ready=%b valid=%b exp 1/0", bus.ready, bus.out_valid);
        end
        checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL mid_reset_data got=%h exp=0", bus.out_data); end
        accept(0, 32'h1, 6'($urandom_range(0, 31)));
        wait_valid(0, n);
        checks++; if (n != LAT || bus.out_data !== 32'h00001000) begin
            failures++; $display("FAIL mid_reset_key lat=%0d data=%h exp %0d/00001000", n, bus.out_data, LAT);
        end
        ack(0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] k, dd, exp_q[$], e;
        int r, acc;
        do_reset();
        k = $urandom;
        program_key(0, k, 1);
        acc = 0;
        for (int cyc = 0; cyc < 6 * PERIOD; cyc++) begin
            dd = $urandom; r = $urandom_range(0, 31);
            checks++; if (bus.ready !== (cyc % PERIOD == 0)) begin
                failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, bus.ready, cyc % PERIOD == 0);
            end
            if (cyc % PERIOD == 0) begin
                exp_q.push_back(model(k, dd, r));
                acc++;
            end
            drive(0, dd, 6'(r), 1'b0, 1'b1, 1'b1);
            step();
            checks++; if (bus.overrun !== (cyc % PERIOD != 0)) begin
                failures++; $display("FAIL b2b_overrun cyc=%0d got=%b exp=%b", cyc, bus.overrun, cyc % PERIOD != 0);
            end
            checks++; if (bus.out_valid !== (cyc % PERIOD == LAT)) begin
                failures++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, cyc % PERIOD == LAT);
            end
            if (cyc % PERIOD == LAT && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus.out_data !== e) begin
                    failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, bus.out_data, e);
                end
            end
        end
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (exp_q.size() != 0 || acc != 6) begin
            failures++; $display("FAIL b2b_drain left=%0d accepts=%0d exp 0/6", exp_q.size(), acc);
        end
    endtask

    task automatic test_random();
        logic [31:0] keys [2];
        logic [31:0] dd, e;
        int sel, r, n;
        do_reset();
        keys[0] = '0; keys[1] = '0;
        for (int it = 0; it < 16; it++) begin
            sel = it % 2;
            if ($urandom_range(0, 1) == 1) begin
                keys[sel] = $urandom;
                program_key(sel, keys[sel], $urandom_range(1, 3));
            end
            dd = $urandom;
            r  = (sel == 0) ? $urandom_range(0, 31) : $urandom_range(0, 63);
            e  = model(keys[sel], dd, r);
            accept(sel, dd, 6'(r));
            wait_valid(sel, n);
            checks++; if (n != LAT || o_data(sel) !== e) begin
                failures++; $display("FAIL rand it=%0d lane=%0d lat=%0d data=%h exp %0d/%h", it, sel, n, o_data(sel), LAT, e);
            end
            repeat ($urandom_range(0, 3)) step();
            checks++; if (o_valid(sel) !== 1'b1 || o_ovr(sel) !== 1'b0) begin
                failures++; $display("FAIL rand_hold it=%0d valid=%b ovr=%b exp 1/0", it, o_valid(sel), o_ovr(sel));
            end
            ack(sel);
            checks++; if (o_ready(sel) !== 1'b1) begin
                failures++; $display("FAIL rand_ack it=%0d ready=%b exp=1", it, o_ready(sel));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_all();
        test_reset();
        test_program_encrypt();
        test_zero_key();
        test_rotation_wrap();
        test_overrun_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
